// File: rtl/spi_master_ctrl_if.sv
// Request/response bus and SPI pins of spi_master_ctrl.
// master: the SPI master block itself (owns the SPI pins and the response side).
// slave : the requester / environment driving requests and spi_miso.
interface spi_master_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int REG_W  = 8
);
  logic              ena;
  logic [1:0]        mode;
  logic              req_vld;
  logic              req_rdy;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [REG_W-1:0]  req_wdata;
  logic              rsp_vld;
  logic [REG_W-1:0]  rsp_rdata;
  logic              busy;
  logic              spi_cs_n;
  logic              spi_clk;
  logic              spi_mosi;
  logic              spi_miso;

  modport master (
    input  ena, mode, req_vld, req_we, req_addr, req_wdata, spi_miso,
    output req_rdy, rsp_vld, rsp_rdata, busy, spi_cs_n, spi_clk, spi_mosi
  );

  modport slave (
    output ena, mode, req_vld, req_we, req_addr, req_wdata, spi_miso,
    input  req_rdy, rsp_vld, rsp_rdata, busy, spi_cs_n, spi_clk, spi_mosi
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// Register-access SPI master: one frame of {R/W, address, data}, MSB first,
// in any of the four SPI modes, with a half-period down-counter timebase.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | cs_n high, waiting for an accepted request
// S_SETUP | cs_n low, first frame bit on mosi, one half-period
// S_SHIFT | 2N half-periods, spi_clk toggles at each terminal count
// S_HOLD  | cs_n low, spi_clk back at CPOL, one half-period
// S_GAP   | cs_n high, rsp_vld on first cycle, one half-period
module spi_master_ctrl #(
  parameter int ADDR_W  = 4,
  parameter int REG_W   = 8,
  parameter int CLK_DIV = 2
) (
  input logic               clk,
  input logic               rst,
  spi_master_ctrl_if.master bus
);

  localparam int N  = 1 + ADDR_W + REG_W;
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HW = $clog2(2 * N);

  localparam logic [CW-1:0] CNT_LOAD  = CW'(CLK_DIV - 1);
  localparam logic [HW-1:0] HCNT_LOAD = HW'(2 * N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [HW-1:0]    r_hcnt;
  logic             r_sclk;
  logic             r_cpol;
  logic             r_cpha;
  logic [N-1:0]     r_tx;
  logic [REG_W-1:0] r_rx;
  logic             r_rsp_vld;
  logic [REG_W-1:0] r_rsp_rdata;

  logic w_tc;
  logic w_accept;
  logic w_load;
  logic w_leading;
  logic w_sample;
  logic w_shift;
  logic w_cs_active;

  assign w_tc        = (r_cnt == '0);
  assign w_accept    = (r_state == S_IDLE) && bus.ena && bus.req_vld;
  assign w_load      = (r_state != w_state_nxt) || ((r_state == S_SHIFT) && w_tc);
  // Half-period index t = 2N-1-r_hcnt; even t (odd r_hcnt) ends on a leading edge.
  assign w_leading   = r_hcnt[0];
  assign w_sample    = w_leading ^ r_cpha;
  // CPHA=1 already shows the MSB, so the first leading edge must not shift.
  assign w_shift     = r_cpha ? (w_leading && (r_hcnt != HCNT_LOAD)) : !w_leading;
  assign w_cs_active = (r_state == S_SETUP) || (r_state == S_SHIFT) || (r_state == S_HOLD);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode, each non-idle state paced by the half-period counter.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_SETUP;
      S_SETUP: if (w_tc) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_tc && (r_hcnt == '0)) w_state_nxt = S_HOLD;
      S_HOLD:  if (w_tc) w_state_nxt = S_GAP;
      S_GAP:   if (w_tc) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Timebase, request latch, shift registers and response capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_hcnt      <= '0;
      r_sclk      <= 1'b0;
      r_cpol      <= 1'b0;
      r_cpha      <= 1'b0;
      r_tx        <= '0;
      r_rx        <= '0;
      r_rsp_vld   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_vld <= 1'b0;
      if (w_load) begin
        r_cnt <= CNT_LOAD;
      end else if (!w_tc) begin
        r_cnt <= r_cnt - 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          // Tracking CPOL while idle keeps spi_clk at the requested level,
          // and the acceptance edge leaves it latched for the frame.
          r_cpol <= bus.mode[1];
          if (w_accept) begin
            r_cpha <= bus.mode[0];
            r_tx   <= {bus.req_we, bus.req_addr, bus.req_wdata & {REG_W{bus.req_we}}};
          end
        end
        S_SETUP: begin
          r_sclk <= r_cpol;
          r_hcnt <= HCNT_LOAD;
        end
        S_SHIFT: begin
          if (w_tc) begin
            r_sclk <= ~r_sclk;
            r_hcnt <= r_hcnt - 1'b1;
            if (w_sample) r_rx <= {r_rx[REG_W-2:0], bus.spi_miso};
            if (w_shift)  r_tx <= {r_tx[N-2:0], 1'b0};
          end
        end
        S_HOLD: begin
          if (w_tc) begin
            r_rsp_vld   <= 1'b1;
            r_rsp_rdata <= r_rx;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.spi_cs_n  = !w_cs_active;
  assign bus.spi_clk   = rst ? bus.mode[1] : ((r_state == S_SHIFT) ? r_sclk : r_cpol);
  assign bus.spi_mosi  = w_cs_active && r_tx[N-1];
  assign bus.req_rdy   = !rst && (r_state == S_IDLE) && bus.ena;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.rsp_vld   = r_rsp_vld;
  assign bus.rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: event-driven SPI slave model plus
// frame-level timing expectations computed from the frame length.
module tb_spi_master_ctrl;
  localparam int ADDR_W  = 4;
  localparam int REG_W   = 8;
  localparam int CLK_DIV = 2;
  localparam int N       = 1 + ADDR_W + REG_W;
  localparam int T_CS    = (2 * N + 2) * CLK_DIV;     // cycles cs_n is low
  localparam int T_RDY   = (2 * N + 3) * CLK_DIV + 1; // cycle req_rdy returns

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  spi_master_ctrl_if #(.ADDR_W(ADDR_W), .REG_W(REG_W)) bus ();

  spi_master_ctrl #(.ADDR_W(ADDR_W), .REG_W(REG_W), .CLK_DIV(CLK_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // ---------------- SPI slave model ----------------
  logic [1:0]       m_mode = 2'b00;
  logic [REG_W-1:0] s_data = '0;
  logic [N-1:0]     s_tx = '0;
  logic [N-1:0]     s_rx = '0;
  int               s_nrx = 0, s_lead = 0, s_trail = 0;
  logic             s_prev_cs = 1'b1;
  logic             s_prev_clk = 1'b0;

  always @(bus.spi_cs_n or bus.spi_clk) begin
    if (bus.spi_cs_n !== 1'b0) begin
      s_prev_cs    = 1'b1;
      bus.spi_miso = 1'b0;
    end else if (s_prev_cs) begin
      s_prev_cs  = 1'b0;
      s_prev_clk = m_mode[1];
      s_tx       = {{(1 + ADDR_W){1'b0}}, s_data};
      s_rx       = '0;
      s_nrx      = 0;
      s_lead     = 0;
      s_trail    = 0;
      bus.spi_miso = m_mode[0] ? 1'b0 : s_tx[N-1];
    end else if (bus.spi_clk !== s_prev_clk) begin
      s_prev_clk = bus.spi_clk;
      if (bus.spi_clk !== m_mode[1]) begin
        s_lead++;
        if (!m_mode[0]) begin
          s_rx = {s_rx[N-2:0], bus.spi_mosi};
          s_nrx++;
        end else if (s_lead <= N) begin
          bus.spi_miso = s_tx[N - s_lead];
        end
      end else begin
        s_trail++;
        if (m_mode[0]) begin
          s_rx = {s_rx[N-2:0], bus.spi_mosi};
          s_nrx++;
        end else if (s_trail < N) begin
          bus.spi_miso = s_tx[N - 1 - s_trail];
        end
      end
    end
  end

  // Length of the most recent run of cs_n high cycles between frames.
  int hi_run = 0, last_gap = 0;
  always @(negedge clk) begin
    if (bus.spi_cs_n === 1'b1) hi_run++;
    else if (hi_run > 0) begin
      last_gap = hi_run;
      hi_run   = 0;
    end
  end

  // ---------------- one full transaction ----------------
  task automatic txn(input logic we, input logic [ADDR_W-1:0] addr, input logic [REG_W-1:0] wd,
                     input logic [1:0] md, input logic [REG_W-1:0] sd,
                     input bit drop_ena, input bit keep_vld, input string tag);
    logic [N-1:0]     exp_frame;
    logic [REG_W-1:0] rdata_at_rsp;
    int n_cs, n_rsp, n_busy, n_rdy, n_idle;
    bit got;
    exp_frame = {we, addr, we ? wd : {REG_W{1'b0}}};
    n_cs = 0; n_rsp = 0; n_busy = 0; n_rdy = 0; n_idle = 0;
    got = 1'b0;
    rdata_at_rsp = 'x;
    @(negedge clk);
    bus.req_vld   = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.mode      = md;
    m_mode        = md;
    s_data        = sd;
    for (int i = 0; i < 100; i++) begin
      if (bus.req_rdy === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk1({tag, " accept"}, got, 1'b1);
    if (!got) begin
      bus.req_vld = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    // Request fields and mode are scrambled after acceptance; the frame must not notice.
    bus.req_we    = ~we;
    bus.req_addr  = addr ^ {ADDR_W{1'b1}};
    bus.req_wdata = wd ^ {REG_W{1'b1}};
    bus.mode      = ~md;
    if (!keep_vld) bus.req_vld = 1'b0;
    if (drop_ena)  bus.ena = 1'b0;
    for (int c = 1; c <= T_RDY; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      if (bus.spi_cs_n !== (c > T_CS)) n_cs++;
      if (bus.rsp_vld !== (c == T_CS + 1)) n_rsp++;
      if (c == T_CS + 1) rdata_at_rsp = bus.rsp_rdata;
      if (bus.busy !== (c < T_RDY)) n_busy++;
      if (c < T_RDY && bus.req_rdy !== 1'b0) n_rdy++;
      if (bus.spi_cs_n && bus.spi_mosi !== 1'b0) n_idle++;
      if (bus.spi_cs_n && bus.busy && bus.spi_clk !== md[1]) n_idle++;
    end
    chk({tag, " cs_n window"}, n_cs, 0);
    chk({tag, " rsp_vld pulse"}, n_rsp, 0);
    chk({tag, " busy window"}, n_busy, 0);
    chk({tag, " req_rdy holdoff"}, n_rdy, 0);
    chk({tag, " idle lines"}, n_idle, 0);
    chk({tag, " rsp_rdata"}, 32'(rdata_at_rsp), 32'(sd));
    chk({tag, " rsp_rdata hold"}, 32'(bus.rsp_rdata), 32'(sd));
    chk({tag, " mosi frame"}, 32'(s_rx), 32'(exp_frame));
    chk({tag, " bits sampled"}, s_nrx, N);
    chk({tag, " leading edges"}, s_lead, N);
    chk({tag, " trailing edges"}, s_trail, N);
    chk1({tag, " req_rdy return"}, bus.req_rdy, !drop_ena);
    if (drop_ena) begin
      n_rdy = 0;
      bus.req_vld = 1'b1;
      repeat (6) begin
        @(posedge clk);
        #1;
        if (bus.req_rdy !== 1'b0 || bus.spi_cs_n !== 1'b1) n_rdy++;
      end
      chk({tag, " ena low holdoff"}, n_rdy, 0);
      @(negedge clk);
      bus.req_vld = 1'b0;
      bus.ena     = 1'b1;
      #1;
      chk1({tag, " ena restore rdy"}, bus.req_rdy, 1'b1);
    end
  endtask

  initial begin
    int n;
    bit got;
    rst           = 1'b1;
    bus.ena       = 1'b1;
    bus.mode      = 2'b10;
    bus.req_vld   = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk1("reset cs_n", bus.spi_cs_n, 1'b1);
    chk1("reset spi_clk cpol1", bus.spi_clk, 1'b1);
    chk1("reset mosi", bus.spi_mosi, 1'b0);
    chk1("reset req_rdy", bus.req_rdy, 1'b0);
    chk1("reset rsp_vld", bus.rsp_vld, 1'b0);
    chk1("reset busy", bus.busy, 1'b0);
    chk("reset rsp_rdata", 32'(bus.rsp_rdata), 0);
    bus.mode = 2'b01;
    #1;
    chk1("reset spi_clk live", bus.spi_clk, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk1("post-reset req_rdy", bus.req_rdy, 1'b1);

    // Directed frames.
    txn(1'b1, 4'h3, 8'hA5, 2'b00, 8'h3C, 1'b0, 1'b0, "mode0_write");
    txn(1'b0, 4'h9, 8'h77, 2'b11, 8'hCA, 1'b0, 1'b0, "mode3_read");
    txn(1'b0, 4'h8, 8'h00, 2'b01, 8'h5A, 1'b0, 1'b0, "mode1_read");
    txn(1'b0, 4'h8, 8'h00, 2'b10, 8'h5A, 1'b0, 1'b0, "mode2_read");

    // req_vld held high across two requests.
    txn(1'b1, 4'h2, 8'h81, 2'b00, 8'h11, 1'b0, 1'b1, "b2b_first");
    txn(1'b0, 4'hE, 8'h00, 2'b00, 8'hE7, 1'b0, 1'b0, "b2b_second");
    chk1("b2b cs_n gap", last_gap >= CLK_DIV, 1'b1);

    // ena dropped mid-frame.
    txn(1'b1, 4'h6, 8'h42, 2'b01, 8'h99, 1'b1, 1'b0, "ena_drop");

    // rst pulsed around frame bit 6.
    @(negedge clk);
    bus.req_vld   = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 4'h5;
    bus.req_wdata = 8'h3C;
    bus.mode      = 2'b10;
    m_mode        = 2'b10;
    s_data        = 8'hF0;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.req_rdy === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk1("abort accept", got, 1'b1);
    @(posedge clk);
    #1;
    bus.req_vld = 1'b0;
    repeat (CLK_DIV * 13 - 1) @(posedge clk);
    #1;
    chk1("abort mid-frame busy", bus.busy, 1'b1);
    rst = 1'b1;
    #1;
    chk1("abort cs_n", bus.spi_cs_n, 1'b1);
    chk1("abort mosi", bus.spi_mosi, 1'b0);
    chk1("abort busy", bus.busy, 1'b0);
    chk1("abort rsp_vld", bus.rsp_vld, 1'b0);
    chk1("abort spi_clk", bus.spi_clk, 1'b1);
    chk("abort rsp_rdata", 32'(bus.rsp_rdata), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk1("abort release rdy", bus.req_rdy, 1'b1);
    n = 0;
    repeat (T_RDY) begin
      @(posedge clk);
      #1;
      if (bus.rsp_vld !== 1'b0 || bus.spi_cs_n !== 1'b1) n++;
    end
    chk("abort no response", n, 0);
    txn(1'b0, 4'hA, 8'h00, 2'b00, 8'hB4, 1'b0, 1'b0, "after_abort");

    // Randomized frames.
    for (int t = 0; t < 8; t++) begin
      txn(1'($urandom_range(0, 1)), ADDR_W'($urandom), REG_W'($urandom),
          2'($urandom_range(0, 3)), REG_W'($urandom), 1'b0, 1'b0, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
